// File: rtl/csr_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// kasumi_csr_pkg
// Shared definitions for the CSR access unit: machine-mode CSR addresses,
// Zicsr funct3 encodings, mstatus bit positions, the sequencer state enum and
// the mstatus rewrite helpers used on trap entry and MRET.
// -----------------------------------------------------------------------------
package kasumi_csr_pkg;

    localparam int CSR_ADDR_W = 12;
    localparam int CSR_DATA_W = 32;

    // Machine-mode CSR addresses touched by trap entry / MRET
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // Zicsr funct3 encodings
    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RD        = 4'd1,
        ST_WR        = 4'd2,
        ST_T_EPC     = 4'd3,
        ST_T_CAUSE   = 4'd4,
        ST_T_TVAL    = 4'd5,
        ST_T_STAT_RD = 4'd6,
        ST_T_STAT_WR = 4'd7,
        ST_M_EPC     = 4'd8,
        ST_M_STAT_RD = 4'd9,
        ST_M_STAT_WR = 4'd10,
        ST_DONE      = 4'd11
    } csr_state_e;

    // CSRs whose address top bits are 2'b11 are read-only
    function automatic logic is_read_only(input logic [11:0] num);
        return (num[11:10] == 2'b11);
    endfunction

    // Trap entry: stack MIE into MPIE, disable interrupts, previous mode = M
    function automatic logic [31:0] trap_mstatus(input logic [31:0] mstatus);
        logic [31:0] res;
        res                                = mstatus;
        res[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
        res[MSTATUS_MIE]                   = 1'b0;
        res[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return res;
    endfunction

    // MRET: restore MIE from MPIE, set MPIE, MPP stays machine mode
    function automatic logic [31:0] mret_mstatus(input logic [31:0] mstatus);
        logic [31:0] res;
        res                                = mstatus;
        res[MSTATUS_MIE]                   = mstatus[MSTATUS_MPIE];
        res[MSTATUS_MPIE]                  = 1'b1;
        res[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return res;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// -----------------------------------------------------------------------------
// csr_access_unit_if
// Bus between the CSR access unit (master) and the CSR register file (slave):
// one combinational read port and one write port.
//   csr_addr   : read address            (master -> slave)
//   csr_rdata  : combinational read data (slave  -> master)
//   wb_csr     : write strobe            (master -> slave)
//   write_addr : write address           (master -> slave)
//   in_data    : write data              (master -> slave)
// -----------------------------------------------------------------------------
interface csr_access_unit_if;
    import kasumi_csr_pkg::*;

    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [CSR_DATA_W-1:0] csr_rdata;
    logic                  wb_csr;
    logic [CSR_ADDR_W-1:0] write_addr;
    logic [CSR_DATA_W-1:0] in_data;

    modport master (
        output csr_addr,
        output wb_csr,
        output write_addr,
        output in_data,
        input  csr_rdata
    );

    modport slave (
        input  csr_addr,
        input  wb_csr,
        input  write_addr,
        input  in_data,
        output csr_rdata
    );

endinterface

// File: rtl/csr_access_unit_alu.sv
// -----------------------------------------------------------------------------
// csr_alu
// Combinational read-modify-write datapath for Zicsr instructions.
//   op           : funct3
//   src          : rs1 value or zero-extended zimm
//   src_is_zero  : rs1 index / zimm is zero (suppresses set/clear writes)
//   old_value    : current CSR contents
//   new_value    : value to write back
//   write_needed : the instruction performs a write
// -----------------------------------------------------------------------------
module csr_alu
    import kasumi_csr_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] src,
    input  logic        src_is_zero,
    input  logic [31:0] old_value,
    output logic [31:0] new_value,
    output logic        write_needed
);

    // New value and write-needed flag per funct3
    always_comb begin
        new_value    = old_value;
        write_needed = 1'b0;
        case (op)
            F3_RW, F3_RWI: begin
                new_value    = src;
                write_needed = 1'b1;
            end
            F3_RS, F3_RSI: begin
                new_value    = old_value | src;
                write_needed = ~src_is_zero;
            end
            F3_RC, F3_RCI: begin
                new_value    = old_value & ~src;
                write_needed = ~src_is_zero;
            end
            default: begin
                new_value    = old_value;
                write_needed = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// -----------------------------------------------------------------------------
// csr_access_unit
// Sequencing master for the CSR register file. Runs Zicsr read-modify-write
// transactions, machine-mode trap entry and MRET over a single read port and
// a single write port.
//   clk, rst        : clock, asynchronous active-high reset
//   csr_req ..      : Zicsr request (op, number, source, source-is-zero)
//   trap_req ..     : trap entry request (pc, cause, tval)
//   mret_req        : MRET request
//   csr_bus         : CSR file bus (master modport)
//   busy            : transaction in progress
//   done            : one-cycle completion pulse
//   rd_data         : old CSR value of the last CSR operation
//   illegal         : qualifies done, write to a read-only CSR attempted
//   redirect        : qualifies done for trap entry / MRET
//   redirect_pc     : new PC, valid with redirect
// All outputs are registered: each is computed from the next state so it is
// valid for the whole cycle the FSM spends in the matching state. The read
// address therefore reaches the CSR file at the start of a read state and the
// combinational read data is captured at the end of it.
// -----------------------------------------------------------------------------
module csr_access_unit
    import kasumi_csr_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_req,
    input  logic [2:0]          csr_op,
    input  logic [11:0]         csr_num,
    input  logic [31:0]         csr_src,
    input  logic                src_is_zero,
    input  logic                trap_req,
    input  logic [31:0]         trap_pc,
    input  logic [31:0]         trap_cause,
    input  logic [31:0]         trap_tval,
    input  logic                mret_req,
    csr_access_unit_if.master   csr_bus,
    output logic                busy,
    output logic                done,
    output logic [31:0]         rd_data,
    output logic                illegal,
    output logic                redirect,
    output logic [31:0]         redirect_pc
);

    csr_state_e  state_r, state_next_s;
    // Second-cycle marker for the two-cycle mstatus read states
    logic        phase_r, phase_next_s;

    logic [2:0]  op_r;
    logic [11:0] num_r;
    logic [31:0] src_r;
    logic        src_zero_r;
    logic [31:0] cause_r;
    logic [31:0] tval_r;
    logic [31:0] mstatus_r;

    logic [31:0] alu_new_s;
    logic        alu_write_s;
    logic        read_only_s;

    logic [11:0] csr_addr_s,   csr_addr_r;
    logic        wb_csr_s,     wb_csr_r;
    logic [11:0] write_addr_s, write_addr_r;
    logic [31:0] in_data_s,    in_data_r;
    logic        busy_s,       busy_r;
    logic        done_s,       done_r;
    logic        illegal_s,    illegal_r;
    logic        redirect_s,   redirect_r;
    logic [31:0] rd_data_r;
    logic [31:0] redirect_pc_r;

    csr_alu u_alu (
        .op           (op_r),
        .src          (src_r),
        .src_is_zero  (src_zero_r),
        .old_value    (csr_bus.csr_rdata),
        .new_value    (alu_new_s),
        .write_needed (alu_write_s)
    );

    assign read_only_s = is_read_only(num_r);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            phase_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            phase_r <= phase_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        phase_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trap_req) begin
                    state_next_s = ST_T_EPC;
                end else if (mret_req) begin
                    state_next_s = ST_M_EPC;
                end else if (csr_req) begin
                    state_next_s = ST_RD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (alu_write_s && !read_only_s) begin
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_WR:        state_next_s = ST_DONE;
            ST_T_EPC:     state_next_s = ST_T_CAUSE;
            ST_T_CAUSE:   state_next_s = ST_T_TVAL;
            ST_T_TVAL:    state_next_s = ST_T_STAT_RD;
            ST_T_STAT_RD: begin
                // cycle 0 reads mstatus, cycle 1 reads mtvec
                if (!phase_r) begin
                    state_next_s = ST_T_STAT_RD;
                    phase_next_s = 1'b1;
                end else begin
                    state_next_s = ST_T_STAT_WR;
                end
            end
            ST_T_STAT_WR: state_next_s = ST_DONE;
            ST_M_EPC:     state_next_s = ST_M_STAT_RD;
            ST_M_STAT_RD: begin
                // held two cycles so MRET keeps the same read cadence as trap entry
                if (!phase_r) begin
                    state_next_s = ST_M_STAT_RD;
                    phase_next_s = 1'b1;
                end else begin
                    state_next_s = ST_M_STAT_WR;
                end
            end
            ST_M_STAT_WR: state_next_s = ST_DONE;
            ST_DONE:      state_next_s = ST_IDLE;
            default:      state_next_s = ST_IDLE;
        endcase
    end

    // Output decode for the state about to be entered
    always_comb begin
        csr_addr_s   = 12'h000;
        wb_csr_s     = 1'b0;
        write_addr_s = 12'h000;
        in_data_s    = 32'h0000_0000;
        case (state_next_s)
            ST_RD: begin
                csr_addr_s = csr_num;
            end
            ST_WR: begin
                wb_csr_s     = 1'b1;
                write_addr_s = num_r;
                in_data_s    = alu_new_s;
            end
            ST_T_EPC: begin
                // entered straight from IDLE, so the pc comes off the request
                wb_csr_s     = 1'b1;
                write_addr_s = CSR_MEPC;
                in_data_s    = trap_pc & 32'hFFFF_FFFC;
            end
            ST_T_CAUSE: begin
                wb_csr_s     = 1'b1;
                write_addr_s = CSR_MCAUSE;
                in_data_s    = cause_r;
            end
            ST_T_TVAL: begin
                wb_csr_s     = 1'b1;
                write_addr_s = CSR_MTVAL;
                in_data_s    = tval_r;
            end
            ST_T_STAT_RD: begin
                csr_addr_s = phase_next_s ? CSR_MTVEC : CSR_MSTATUS;
            end
            ST_T_STAT_WR: begin
                wb_csr_s     = 1'b1;
                write_addr_s = CSR_MSTATUS;
                in_data_s    = trap_mstatus(mstatus_r);
            end
            ST_M_EPC: begin
                csr_addr_s = CSR_MEPC;
            end
            ST_M_STAT_RD: begin
                csr_addr_s = CSR_MSTATUS;
            end
            ST_M_STAT_WR: begin
                wb_csr_s     = 1'b1;
                write_addr_s = CSR_MSTATUS;
                in_data_s    = mret_mstatus(mstatus_r);
            end
            default: begin
                csr_addr_s   = 12'h000;
                wb_csr_s     = 1'b0;
                write_addr_s = 12'h000;
                in_data_s    = 32'h0000_0000;
            end
        endcase
        busy_s     = (state_next_s != ST_IDLE);
        done_s     = (state_next_s == ST_DONE);
        illegal_s  = (state_r == ST_RD) && alu_write_s && read_only_s;
        redirect_s = (state_r == ST_T_STAT_WR) || (state_r == ST_M_STAT_WR);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_addr_r   <= 12'h000;
            wb_csr_r     <= 1'b0;
            write_addr_r <= 12'h000;
            in_data_r    <= 32'h0000_0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            illegal_r    <= 1'b0;
            redirect_r   <= 1'b0;
        end else begin
            csr_addr_r   <= csr_addr_s;
            wb_csr_r     <= wb_csr_s;
            write_addr_r <= write_addr_s;
            in_data_r    <= in_data_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            illegal_r    <= illegal_s;
            redirect_r   <= redirect_s;
        end
    end

    // Request operand capture on accept (trap wins over MRET wins over CSR)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r       <= 3'b000;
            num_r      <= 12'h000;
            src_r      <= 32'h0000_0000;
            src_zero_r <= 1'b0;
            cause_r    <= 32'h0000_0000;
            tval_r     <= 32'h0000_0000;
        end else if (state_r == ST_IDLE) begin
            if (trap_req) begin
                cause_r <= trap_cause;
                tval_r  <= trap_tval;
            end else if (!mret_req && csr_req) begin
                op_r       <= csr_op;
                num_r      <= csr_num;
                src_r      <= csr_src;
                src_zero_r <= src_is_zero;
            end
        end
    end

    // Read data capture: old CSR value, mstatus snapshot, redirect target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r     <= 32'h0000_0000;
            mstatus_r     <= 32'h0000_0000;
            redirect_pc_r <= 32'h0000_0000;
        end else begin
            if (state_r == ST_RD) begin
                rd_data_r <= csr_bus.csr_rdata;
            end
            if (((state_r == ST_T_STAT_RD) || (state_r == ST_M_STAT_RD)) && !phase_r) begin
                mstatus_r <= csr_bus.csr_rdata;
            end
            if ((state_r == ST_T_STAT_RD) && phase_r) begin
                redirect_pc_r <= csr_bus.csr_rdata & 32'hFFFF_FFFC;
            end else if (state_r == ST_M_EPC) begin
                redirect_pc_r <= csr_bus.csr_rdata;
            end
        end
    end

    assign csr_bus.csr_addr   = csr_addr_r;
    assign csr_bus.wb_csr     = wb_csr_r;
    assign csr_bus.write_addr = write_addr_r;
    assign csr_bus.in_data    = in_data_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign illegal            = illegal_r;
    assign redirect           = redirect_r;
    assign rd_data            = rd_data_r;
    assign redirect_pc        = redirect_pc_r;

endmodule

// File: tb/tb_csr_access_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_access_unit
// Bench for csr_access_unit with a behavioural CSR file on the slave side.
// Expected writes and completions are queued when a request is driven and
// compared by a monitor when the unit produces them (cycle, address, data,
// flags). CSR operations come from a vector table; trap, MRET, request
// priority and mid-transaction reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_csr_access_unit;
    import kasumi_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req;
    logic [2:0]  csr_op;
    logic [11:0] csr_num;
    logic [31:0] csr_src;
    logic        src_is_zero;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        mret_req;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic        illegal;
    logic        redirect;
    logic [31:0] redirect_pc;

    csr_access_unit_if bus ();

    csr_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .csr_req     (csr_req),
        .csr_op      (csr_op),
        .csr_num     (csr_num),
        .csr_src     (csr_src),
        .src_is_zero (src_is_zero),
        .trap_req    (trap_req),
        .trap_pc     (trap_pc),
        .trap_cause  (trap_cause),
        .trap_tval   (trap_tval),
        .mret_req    (mret_req),
        .csr_bus     (bus),
        .busy        (busy),
        .done        (done),
        .rd_data     (rd_data),
        .illegal     (illegal),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    // Behavioural CSR file: combinational read, write on clock edge
    logic [31:0] mem [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h000;
    logic [31:0] pre_data = 32'h0;
    assign bus.csr_rdata = mem[bus.csr_addr];
    always @(posedge clk) begin
        if (bus.wb_csr) mem[bus.write_addr] <= bus.in_data;
        else if (pre_en) mem[pre_addr] <= pre_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wr_exp_t;
    typedef struct { int cyc; logic [31:0] rd; logic ill; logic redir; logic [31:0] pc; } done_exp_t;
    typedef struct {
        logic [2:0]  op;   logic [11:0] num; logic [31:0] src; logic zero;
        logic [31:0] old;  logic wr; logic [31:0] wdata; logic ill;
    } vec_t;

    wr_exp_t   wq [$];
    done_exp_t dq [$];
    vec_t      vecs [$];
    wr_exp_t   we;
    done_exp_t de;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.wb_csr) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%03h data 0x%08h at cycle %0d, none expected",
                         bus.write_addr, bus.in_data, cyc);
            end else begin
                we = wq.pop_front();
                check("wr_cycle", 32'(cyc), 32'(we.cyc));
                check("wr_addr", {20'h0, bus.write_addr}, {20'h0, we.addr});
                check("wr_data", bus.in_data, we.data);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d, none expected", cyc);
            end else begin
                de = dq.pop_front();
                check("done_cycle", 32'(cyc), 32'(de.cyc));
                check("done_busy", {31'h0, busy}, 32'h1);
                check("illegal", {31'h0, illegal}, {31'h0, de.ill});
                check("redirect", {31'h0, redirect}, {31'h0, de.redir});
                check("rd_data", rd_data, de.rd);
                if (de.redir) check("redirect_pc", redirect_pc, de.pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_en   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 20 cycles", name);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] last_rd;

        rst = 1'b1; csr_req = 1'b0; csr_op = 3'b000; csr_num = 12'h000;
        csr_src = 32'h0; src_is_zero = 1'b0; trap_req = 1'b0; trap_pc = 32'h0;
        trap_cause = 32'h0; trap_tval = 32'h0; mret_req = 1'b0;

        //        op      num      src            zero  old            wr    wdata          ill
        vecs.push_back(vec_t'{F3_RW,  12'h340, 32'hDEADBEEF, 1'b0, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0});
        vecs.push_back(vec_t'{F3_RS,  12'h300, 32'h00000000, 1'b1, 32'h00000008, 1'b0, 32'h00000000, 1'b0});
        vecs.push_back(vec_t'{F3_RC,  12'hC00, 32'h00000001, 1'b0, 32'h00000055, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back(vec_t'{F3_RS,  12'h340, 32'h000000F0, 1'b0, 32'h0000000F, 1'b1, 32'h000000FF, 1'b0});
        vecs.push_back(vec_t'{F3_RC,  12'h340, 32'h0000000F, 1'b0, 32'h000000FF, 1'b1, 32'h000000F0, 1'b0});
        vecs.push_back(vec_t'{F3_RWI, 12'h305, 32'h0000001F, 1'b0, 32'h0000AAAA, 1'b1, 32'h0000001F, 1'b0});
        vecs.push_back(vec_t'{F3_RWI, 12'h305, 32'h00000000, 1'b1, 32'h00001234, 1'b1, 32'h00000000, 1'b0});
        vecs.push_back(vec_t'{F3_RSI, 12'h343, 32'h00000005, 1'b0, 32'h00000010, 1'b1, 32'h00000015, 1'b0});
        vecs.push_back(vec_t'{F3_RCI, 12'h343, 32'h00000000, 1'b1, 32'h00000077, 1'b0, 32'h00000000, 1'b0});
        vecs.push_back(vec_t'{F3_RW,  12'hC01, 32'h00000005, 1'b0, 32'h00000099, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back(vec_t'{F3_RS,  12'hF11, 32'h00000000, 1'b1, 32'h00000ABC, 1'b0, 32'h00000000, 1'b0});

        // Reset state
        repeat (3) step();
        check("rst_busy",        {31'h0, busy},     32'h0);
        check("rst_done",        {31'h0, done},     32'h0);
        check("rst_illegal",     {31'h0, illegal},  32'h0);
        check("rst_redirect",    {31'h0, redirect}, 32'h0);
        check("rst_rd_data",     rd_data,           32'h0);
        check("rst_redirect_pc", redirect_pc,       32'h0);
        check("rst_wb_csr",      {31'h0, bus.wb_csr}, 32'h0);
        check("rst_csr_addr",    {20'h0, bus.csr_addr}, 32'h0);
        check("rst_write_addr",  {20'h0, bus.write_addr}, 32'h0);
        check("rst_in_data",     bus.in_data,       32'h0);
        rst = 1'b0;
        step();

        // CSR operations from the table
        last_rd = 32'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            poke(vecs[i].num, vecs[i].old);
            csr_req = 1'b1; csr_op = vecs[i].op; csr_num = vecs[i].num;
            csr_src = vecs[i].src; src_is_zero = vecs[i].zero;
            n = cyc;
            if (vecs[i].wr) wq.push_back(wr_exp_t'{n + 2, vecs[i].num, vecs[i].wdata});
            dq.push_back(done_exp_t'{(vecs[i].wr ? n + 3 : n + 2), vecs[i].old, vecs[i].ill, 1'b0, 32'h0});
            last_rd = vecs[i].old;
            step();
            csr_req = 1'b0;
            check("busy_after_accept", {31'h0, busy}, 32'h1);
            wait_done("csr_op");
            check("idle_after_done", {31'h0, busy}, 32'h0);
        end

        // Trap entry with a simultaneous CSR request: trap wins
        poke(CSR_MTVEC, 32'h80000101);
        poke(CSR_MSTATUS, 32'h00000008);
        trap_req = 1'b1; trap_pc = 32'h00001002; trap_cause = 32'h2; trap_tval = 32'h00000BAD;
        csr_req = 1'b1; csr_op = F3_RW; csr_num = 12'h340; csr_src = 32'h1111; src_is_zero = 1'b0;
        n = cyc;
        wq.push_back(wr_exp_t'{n + 1, CSR_MEPC,    32'h00001000});
        wq.push_back(wr_exp_t'{n + 2, CSR_MCAUSE,  32'h00000002});
        wq.push_back(wr_exp_t'{n + 3, CSR_MTVAL,   32'h00000BAD});
        wq.push_back(wr_exp_t'{n + 6, CSR_MSTATUS, 32'h00001880});
        dq.push_back(done_exp_t'{n + 7, last_rd, 1'b0, 1'b1, 32'h80000100});
        step();
        trap_req = 1'b0; csr_req = 1'b0;
        wait_done("trap");

        // MRET
        poke(CSR_MEPC, 32'h00002000);
        poke(CSR_MSTATUS, 32'h00001880);
        mret_req = 1'b1;
        n = cyc;
        wq.push_back(wr_exp_t'{n + 4, CSR_MSTATUS, 32'h00001888});
        dq.push_back(done_exp_t'{n + 5, last_rd, 1'b0, 1'b1, 32'h00002000});
        step();
        mret_req = 1'b0;
        wait_done("mret");
        check("mret_mstatus_mem", mem[CSR_MSTATUS], 32'h00001888);

        // Reset in the second cycle of a trap: only the mepc write happens
        trap_req = 1'b1; trap_pc = 32'h00003004; trap_cause = 32'h7; trap_tval = 32'h00000055;
        n = cyc;
        wq.push_back(wr_exp_t'{n + 1, CSR_MEPC, 32'h00003004});
        step();
        trap_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("midrst_wb_csr",      {31'h0, bus.wb_csr}, 32'h0);
        check("midrst_busy",        {31'h0, busy},       32'h0);
        check("midrst_in_data",     bus.in_data,         32'h0);
        check("midrst_rd_data",     rd_data,             32'h0);
        check("midrst_redirect_pc", redirect_pc,         32'h0);
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();
        check("midrst_mcause_kept", mem[CSR_MCAUSE], 32'h00000002);
        check("midrst_mtval_kept",  mem[CSR_MTVAL],  32'h00000BAD);
        check("pending_writes", 32'(wq.size()), 32'h0);
        check("pending_dones",  32'(dq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
